// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared definitions for the sequential binary-to-BCD converter.
//   * FSM state encoding (localparams + enum built from them)
//   * min_digits(): smallest BCD digit count able to hold a bin_w-bit value,
//     used by the converter to reject undersized DIGITS at elaboration.
package bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_e;

    // ceil(bin_w * log10(2)) in integer arithmetic (log10(2) ~= 0.30103).
    function automatic int min_digits(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj -- double-dabble digit correction.
//   dig_i : current 4-bit BCD digit
//   dig_o : dig_i + 3 when dig_i >= 5, else dig_i
// Adding 3 before the left shift makes the shifted digit carry into the
// next decade instead of becoming an illegal code (10..15).
module bcd_digit_adj (
    input  logic [3:0] dig_i,
    output logic [3:0] dig_o
);

    assign dig_o = (dig_i >= 4'd5) ? dig_i + 4'd3 : dig_i;

endmodule

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter -- bit-serial (double dabble) binary to packed BCD.
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : request, only honoured in IDLE
//   bin_in       : operand, captured on accept
//   signed_mode  : two's-complement operand (only when SIGNED_EN=1)
//   busy         : high from the cycle after accept through the DONE cycle
//   done         : one-cycle pulse, bcd_out/negative valid
//   bcd_out      : DIGITS packed digits, ones digit in [3:0]
//   negative     : sign of the last converted operand
// One operand bit is consumed per SHIFT cycle, so a conversion takes
// BIN_W SHIFT cycles followed by a single DONE cycle.
module bcd_seq_converter #(
    parameter int BIN_W     = 16,
    parameter int DIGITS    = 5,
    parameter int SIGNED_EN = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  signed_mode,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  negative
);
    import bcd_pkg::*;

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int ACC_W = 4 * DIGITS;

    if (BIN_W < 4 || BIN_W > 32 || DIGITS < min_digits(BIN_W)) begin : g_param_chk
        $error("bcd_seq_converter: BIN_W=%0d needs BIN_W in 4..32 and DIGITS >= %0d (got %0d)",
               BIN_W, min_digits(BIN_W), DIGITS);
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [BIN_W-1:0]   opr_q,   opr_d;
    logic               sign_q,  sign_d;
    logic [ACC_W-1:0]   bcd_q,   bcd_d;
    logic               neg_q,   neg_d;

    // Per-digit add-3 correction applied to the accumulator before the shift.
    logic [ACC_W-1:0]   acc_adj;
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .dig_i (acc_q[4*g +: 4]),
            .dig_o (acc_adj[4*g +: 4])
        );
    end

    // The top accumulator bit shifts out; with DIGITS sized correctly it is
    // always zero, so it is intentionally dropped.
    logic adj_msb_unused;
    assign adj_msb_unused = acc_adj[ACC_W-1];

    logic [ACC_W-1:0]   acc_sh;
    logic [BIN_W-1:0]   opr_sh;
    assign acc_sh = {acc_adj[ACC_W-2:0], opr_q[BIN_W-1]};
    assign opr_sh = {opr_q[BIN_W-2:0], 1'b0};

    // Negative operands are converted as their magnitude; the BIN_W-bit
    // negation of the most negative value yields 2^(BIN_W-1) as unsigned.
    logic               in_neg;
    logic [BIN_W-1:0]   in_mag;
    assign in_neg = (SIGNED_EN != 0) && signed_mode && bin_in[BIN_W-1];
    assign in_mag = in_neg ? (~bin_in + BIN_W'(1)) : bin_in;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opr_d   = opr_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    opr_d   = in_mag;
                    sign_d  = in_neg;
                    acc_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_d = acc_sh;
                opr_d = opr_sh;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Result registers load on the edge entering DONE.
                    bcd_d   = acc_sh;
                    neg_d   = sign_q;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opr_q   <= '0;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opr_q   <= opr_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign bcd_out  = bcd_q;
    assign negative = neg_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed + small random bench for bcd_seq_converter. Three instances:
//   u0: BIN_W=8,  DIGITS=3, unsigned
//   u1: BIN_W=16, DIGITS=5, unsigned
//   u2: BIN_W=8,  DIGITS=3, SIGNED_EN=1
module tb_bcd_seq_converter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        st0, st1, st2;
    logic [7:0]  b0, b2;
    logic [15:0] b1;
    logic        sm0, sm1, sm2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [11:0] bcd0, bcd2;
    logic [19:0] bcd1;
    logic        neg0, neg1, neg2;

    bcd_seq_converter #(.BIN_W(8), .DIGITS(3), .SIGNED_EN(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .bin_in(b0), .signed_mode(sm0),
        .busy(busy0), .done(done0), .bcd_out(bcd0), .negative(neg0));
    bcd_seq_converter #(.BIN_W(16), .DIGITS(5), .SIGNED_EN(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .bin_in(b1), .signed_mode(sm1),
        .busy(busy1), .done(done1), .bcd_out(bcd1), .negative(neg1));
    bcd_seq_converter #(.BIN_W(8), .DIGITS(3), .SIGNED_EN(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .bin_in(b2), .signed_mode(sm2),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .negative(neg2));

    int errors = 0;
    int checks = 0;
    int sel    = 0;

    logic        o_busy, o_done, o_neg;
    logic [19:0] o_bcd;
    always_comb begin
        o_busy = busy0; o_done = done0; o_neg = neg0; o_bcd = {8'h00, bcd0};
        case (sel)
            1: begin o_busy = busy1; o_done = done1; o_neg = neg1; o_bcd = bcd1; end
            2: begin o_busy = busy2; o_done = done2; o_neg = neg2; o_bcd = {8'h00, bcd2}; end
            default: ;
        endcase
    end

    logic [19:0] prev_bcd [3];
    logic        prev_neg [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int s, input logic go, input logic [31:0] v, input logic sm);
        case (s)
            0: begin st0 = go; b0 = v[7:0];  sm0 = sm; end
            1: begin st1 = go; b1 = v[15:0]; sm1 = sm; end
            default: begin st2 = go; b2 = v[7:0]; sm2 = sm; end
        endcase
    endtask

    // Decimal reference by repeated division (independent of double dabble).
    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // One conversion with per-cycle busy/done/hold checks. With noise set,
    // start is held high (different operand) through SHIFT and DONE and the
    // idle window afterwards must show no second done.
    task automatic conv(input int s, input logic [31:0] v, input logic sm,
                        input logic [19:0] eb, input logic en, input bit noise,
                        input string tag);
        int w;
        w = (s == 1) ? 16 : 8;
        sel = s;
        drive(s, 1'b1, v, sm);
        tick();
        for (int c = 0; c <= w; c++) begin
            if (noise) drive(s, 1'b1, ~v, ~sm);
            else       drive(s, 1'b0, v, sm);
            chk({tag, "/busy"}, 32'(o_busy), 32'd1);
            chk({tag, "/done"}, 32'(o_done), 32'(c == w));
            if (c < w) begin
                chk({tag, "/hold_bcd"}, 32'(o_bcd), 32'(prev_bcd[s]));
                chk({tag, "/hold_neg"}, 32'(o_neg), 32'(prev_neg[s]));
            end else begin
                chk({tag, "/bcd"}, 32'(o_bcd), 32'(eb));
                chk({tag, "/neg"}, 32'(o_neg), 32'(en));
            end
            tick();
        end
        drive(s, 1'b0, v, sm);
        chk({tag, "/idle_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "/idle_done"}, 32'(o_done), 32'd0);
        prev_bcd[s] = eb;
        prev_neg[s] = en;
        if (noise) begin
            for (int c = 0; c < w + 2; c++) begin
                tick();
                chk({tag, "/no_requeue"}, 32'(o_done), 32'd0);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        st0 = 0; st1 = 0; st2 = 0;
        b0 = 8'hA5; b1 = 16'h1234; b2 = 8'h5A;
        sm0 = 0; sm1 = 0; sm2 = 0;
        for (int i = 0; i < 3; i++) begin prev_bcd[i] = '0; prev_neg[i] = 1'b0; end

        // Reset state on all three instances.
        tick(); tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            chk("rst_busy", 32'(o_busy), 32'd0);
            chk("rst_done", 32'(o_done), 32'd0);
            chk("rst_bcd",  32'(o_bcd),  32'd0);
            chk("rst_neg",  32'(o_neg),  32'd0);
        end
        rst_n = 1'b1;
        tick();

        // Unsigned 8-bit: full scale, zero, signed_mode ignored.
        conv(0, 32'd255,  1'b0, 20'h00255, 1'b0, 0, "u8_255");
        conv(0, 32'd0,    1'b0, 20'h00000, 1'b0, 0, "u8_0");
        conv(0, 32'h80,   1'b1, 20'h00128, 1'b0, 0, "u8_sm_ignored");

        // Unsigned 16-bit.
        conv(1, 32'd65535, 1'b0, 20'h65535, 1'b0, 0, "u16_max");
        conv(1, 32'd0,     1'b0, 20'h00000, 1'b0, 0, "u16_0");
        conv(1, 32'd10000, 1'b0, 20'h10000, 1'b0, 0, "u16_10000");
        conv(1, 32'd1,     1'b0, 20'h00001, 1'b0, 0, "u16_1");

        // Signed 8-bit.
        conv(2, 32'h80, 1'b1, 20'h00128, 1'b1, 0, "s8_min");
        conv(2, 32'hFF, 1'b1, 20'h00001, 1'b1, 0, "s8_m1");
        conv(2, 32'h7F, 1'b1, 20'h00127, 1'b0, 0, "s8_max");
        conv(2, 32'hFF, 1'b0, 20'h00255, 1'b0, 0, "s8_unsigned");

        // start held through SHIFT and DONE: one done, first operand's result.
        conv(0, 32'd173, 1'b0, 20'h00173, 1'b0, 1, "u8_noise");
        conv(2, 32'hF6,  1'b1, 20'h00010, 1'b1, 1, "s8_noise");

        // Reset in SHIFT cycle 3 aborts; all outputs cleared, no done follows.
        sel = 0;
        drive(0, 1'b1, 32'd200, 1'b0);
        tick();
        drive(0, 1'b0, 32'd200, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            chk("abort_busy", 32'(o_busy), 32'd0);
            chk("abort_bcd",  32'(o_bcd),  32'd0);
            chk("abort_neg",  32'(o_neg),  32'd0);
            prev_bcd[s] = '0;
            prev_neg[s] = 1'b0;
        end
        sel = 0;
        for (int c = 0; c < 12; c++) begin
            chk("abort_no_done", 32'(o_done), 32'd0);
            tick();
        end
        conv(0, 32'd200, 1'b0, 20'h00200, 1'b0, 0, "u8_after_abort");

        // start together with reset is ignored.
        sel = 1;
        drive(1, 1'b1, 32'd999, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1, 1'b0, 32'd999, 1'b0);
        chk("rst_start_busy", 32'(o_busy), 32'd0);
        tick();
        chk("rst_start_busy2", 32'(o_busy), 32'd0);
        prev_bcd[0] = '0; prev_bcd[1] = '0; prev_bcd[2] = '0;
        prev_neg[0] = 1'b0; prev_neg[1] = 1'b0; prev_neg[2] = 1'b0;

        // Random sweep against the division model.
        for (int i = 0; i < 300; i++) begin
            int unsigned v;
            v = $urandom_range(0, 65535);
            conv(1, 32'(v), 1'b0, to_bcd(v), 1'b0, 0, "rnd_u16");
        end
        for (int i = 0; i < 200; i++) begin
            int unsigned v, mag;
            logic sm, en;
            v  = $urandom_range(0, 255);
            sm = 1'($urandom_range(0, 1));
            en = sm && (v >= 128);
            mag = en ? (256 - v) : v;
            conv(2, 32'(v), sm, to_bcd(mag), en, 0, "rnd_s8");
        end
        for (int i = 0; i < 100; i++) begin
            int unsigned v;
            v = $urandom_range(0, 255);
            conv(0, 32'(v), 1'b0, to_bcd(v), 1'b0, 0, "rnd_u8");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
